// File: rtl/maptable.sv
// Rename map table: per architectural register, the newest in-flight ROB tag
// and whether that tag has written back, with same-cycle writeback forwarding.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package sys_defs_pkg;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } R_TYPE;

    typedef union packed {
        logic [31:0] bits;
        R_TYPE       r;
    } INST;

    typedef struct packed {
        logic [`ROB_TAG_LEN-1:0] rob_tag_val;
        logic                    rob_tag_ready;
    } MAPTABLE_PACKET;

endpackage

module maptable
    import sys_defs_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    commit,
    input  logic [4:0]              rd_commit,
    input  logic [`ROB_TAG_LEN-1:0] rob_entry_commit,
    input  INST                     inst,
    input  logic [4:0]              rd,
    input  logic [`ROB_TAG_LEN-1:0] rob_entry_in,
    input  logic [4:0]              rd_wb,
    input  logic [`ROB_TAG_LEN-1:0] rob_entry_wb,
    input  logic                    valid_wb,
    output MAPTABLE_PACKET          maptable_packet_rs1,
    output MAPTABLE_PACKET          maptable_packet_rs2
);

    localparam int TW = `ROB_TAG_LEN;

    logic [TW-1:0] tag_q [32];
    logic [TW-1:0] tag_d [32];
    logic [31:0]   rdy_q;
    logic [31:0]   rdy_d;

    logic unused_inst;
    assign unused_inst = ^{inst.r.funct7, inst.r.funct3, inst.r.rd, inst.r.opcode};

    // x0 is never tracked, so entry 0 stays tag 0 / not ready forever.
    always_comb begin
        tag_d = tag_q;
        rdy_d = rdy_q;
        if (valid_wb && rd_wb != 5'd0 && tag_q[rd_wb] == rob_entry_wb) begin
            rdy_d[rd_wb] = 1'b1;
        end
        if (commit && rd_commit != 5'd0 && tag_q[rd_commit] == rob_entry_commit) begin
            tag_d[rd_commit] = '0;
            rdy_d[rd_commit] = 1'b0;
        end
        if (rd != 5'd0) begin
            tag_d[rd] = rob_entry_in;
            rdy_d[rd] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                tag_q[i] <= '0;
            end
            rdy_q <= '0;
        end else begin
            tag_q <= tag_d;
            rdy_q <= rdy_d;
        end
    end

    function automatic MAPTABLE_PACKET lookup(input logic [4:0] rs);
        MAPTABLE_PACKET p;
        logic           fwd;
        p   = '0;
        fwd = valid_wb && rd_wb == rs && tag_q[rs] != '0 &&
              rob_entry_wb == tag_q[rs];
        if (rs != 5'd0) begin
            p.rob_tag_val   = tag_q[rs];
            p.rob_tag_ready = rdy_q[rs] | fwd;
        end
        return p;
    endfunction

    always_comb begin
        maptable_packet_rs1 = lookup(inst.r.rs1);
        maptable_packet_rs2 = lookup(inst.r.rs2);
    end

endmodule

// File: tb/tb_maptable.sv
// Self-checking bench for maptable: directed rename/writeback/commit steps,
// then biased random traffic against an array-based reference model.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module tb_maptable;
    import sys_defs_pkg::*;

    localparam int T = `ROB_TAG_LEN;

    logic           clock = 1'b0;
    logic           reset;
    logic           commit;
    logic [4:0]     rd_commit;
    logic [T-1:0]   rob_entry_commit;
    INST            inst;
    logic [4:0]     rd;
    logic [T-1:0]   rob_entry_in;
    logic [4:0]     rd_wb;
    logic [T-1:0]   rob_entry_wb;
    logic           valid_wb;
    MAPTABLE_PACKET maptable_packet_rs1;
    MAPTABLE_PACKET maptable_packet_rs2;

    int checks = 0;
    int errors = 0;

    logic [T-1:0] m_tag [32];
    logic         m_rdy [32];

    always #5 clock = ~clock;

    maptable dut (
        .clock              (clock),
        .reset              (reset),
        .commit             (commit),
        .rd_commit          (rd_commit),
        .rob_entry_commit   (rob_entry_commit),
        .inst               (inst),
        .rd                 (rd),
        .rob_entry_in       (rob_entry_in),
        .rd_wb              (rd_wb),
        .rob_entry_wb       (rob_entry_wb),
        .valid_wb           (valid_wb),
        .maptable_packet_rs1(maptable_packet_rs1),
        .maptable_packet_rs2(maptable_packet_rs2)
    );

    task automatic chk(input string nm, input logic [T:0] got, input logic [T:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got tag=%0d rdy=%0b, expected tag=%0d rdy=%0b",
                   nm, got[T:1], got[0], exp[T:1], exp[0]);
        end
    endtask

    function automatic logic [T:0] model_lookup(input logic [4:0] rs);
        logic fwd;
        if (rs == 5'd0) return '0;
        fwd = valid_wb && rd_wb == rs && m_tag[rs] != '0 && rob_entry_wb == m_tag[rs];
        return {m_tag[rs], m_rdy[rs] | fwd};
    endfunction

    task automatic idle();
        reset            = 1'b0;
        commit           = 1'b0;
        rd_commit        = '0;
        rob_entry_commit = '0;
        inst             = INST'($urandom);
        inst.r.rs1       = 5'd0;
        inst.r.rs2       = 5'd0;
        rd               = '0;
        rob_entry_in     = '0;
        rd_wb            = '0;
        rob_entry_wb     = '0;
        valid_wb         = 1'b0;
    endtask

    task automatic srcs(input logic [4:0] s1, input logic [4:0] s2);
        inst.r.rs1 = s1;
        inst.r.rs2 = s2;
    endtask

    // Check lookups against the model, clock once, and apply the rules.
    task automatic tick(input string nm);
        logic [T-1:0] nt [32];
        logic         nr [32];
        #1;
        chk({nm, "_rs1"}, maptable_packet_rs1, model_lookup(inst.r.rs1));
        chk({nm, "_rs2"}, maptable_packet_rs2, model_lookup(inst.r.rs2));
        @(posedge clock);
        nt = m_tag;
        nr = m_rdy;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                nt[i] = '0;
                nr[i] = 1'b0;
            end
        end else begin
            if (valid_wb && m_tag[rd_wb] == rob_entry_wb) nr[rd_wb] = 1'b1;
            if (commit && m_tag[rd_commit] == rob_entry_commit) begin
                nt[rd_commit] = '0;
                nr[rd_commit] = 1'b0;
            end
            if (rd != 5'd0) begin
                nt[rd] = rob_entry_in;
                nr[rd] = 1'b0;
            end
        end
        m_tag = nt;
        m_rdy = nr;
        #1;
    endtask

    task automatic look(input string nm, input logic [4:0] s1, input logic [T:0] e1);
        idle();
        srcs(s1, 5'd0);
        #1;
        chk(nm, maptable_packet_rs1, e1);
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            idle();
            srcs(5'($urandom), 5'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                rd           = 5'($urandom);
                rob_entry_in = T'($urandom_range(1, (1 << T) - 1));
            end
            valid_wb = $urandom_range(0, 1) == 1;
            rd_wb    = $urandom_range(0, 3) == 0 ? inst.r.rs1 : 5'($urandom);
            rob_entry_wb = $urandom_range(0, 1) == 1 ? m_tag[rd_wb]
                                                     : T'($urandom);
            commit    = $urandom_range(0, 2) == 0;
            rd_commit = $urandom_range(0, 2) == 0 ? rd_wb : 5'($urandom);
            rob_entry_commit = $urandom_range(0, 1) == 1 ? m_tag[rd_commit]
                                                         : T'($urandom);
            tick("rand");
        end
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 32; i++) begin
            idle();
            srcs(5'(i), 5'(31 - i));
            tick(nm);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_tag[i] = '0;
            m_rdy[i] = 1'b0;
        end
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        tick("reset");
        look("reset_r1", 5'd1, '0);
        look("reset_r31", 5'd31, '0);

        idle(); rd = 5'd1; rob_entry_in = 5'd1; tick("ren_r1");
        idle(); rd = 5'd2; rob_entry_in = 5'd2; tick("ren_r2");
        idle(); srcs(5'd0, 5'd1);
        #1;
        chk("chain_rs1_x0", maptable_packet_rs1, '0);
        chk("chain_rs2_r1", maptable_packet_rs2, {5'd1, 1'b0});
        look("chain_r2", 5'd2, {5'd2, 1'b0});
        idle(); rob_entry_in = 5'd3; tick("ren_x0");
        look("x0_keep_r1", 5'd1, {5'd1, 1'b0});
        look("x0_keep_r2", 5'd2, {5'd2, 1'b0});

        idle(); valid_wb = 1'b1; rd_wb = 5'd1; rob_entry_wb = 5'd1; tick("wb_r1");
        look("wb_r1_ready", 5'd1, {5'd1, 1'b1});
        idle(); rd = 5'd1; rob_entry_in = 5'd5; tick("ren_r1_5");
        look("ren_clears_rdy", 5'd1, {5'd5, 1'b0});

        idle(); rd = 5'd2; rob_entry_in = 5'd6; tick("ren_r2_6");
        idle(); valid_wb = 1'b1; rd_wb = 5'd2; rob_entry_wb = 5'd2; tick("wb_stale");
        look("stale_wb", 5'd2, {5'd6, 1'b0});

        idle(); srcs(5'd2, 5'd0);
        valid_wb = 1'b1; rd_wb = 5'd2; rob_entry_wb = 5'd6;
        #1;
        chk("fwd_rs1", maptable_packet_rs1, {5'd6, 1'b1});
        tick("fwd");
        look("fwd_stored", 5'd2, {5'd6, 1'b1});
        idle(); valid_wb = 1'b1; rd_wb = 5'd0; rob_entry_wb = 5'd0;
        #1;
        chk("fwd_x0", maptable_packet_rs1, '0);
        tick("wb_x0");

        idle(); commit = 1'b1; rd_commit = 5'd2; rob_entry_commit = 5'd6; tick("cm_r2");
        look("commit_clear", 5'd2, '0);
        idle(); commit = 1'b1; rd_commit = 5'd1; rob_entry_commit = 5'd3; tick("cm_stale");
        look("commit_stale", 5'd1, {5'd5, 1'b0});

        idle(); rd = 5'd3; rob_entry_in = 5'd4; tick("ren_r3");
        idle(); rd = 5'd3; rob_entry_in = 5'd7;
        valid_wb = 1'b1; rd_wb = 5'd3; rob_entry_wb = 5'd4;
        commit = 1'b1; rd_commit = 5'd3; rob_entry_commit = 5'd4;
        tick("prio3");
        look("prio_ren", 5'd3, {5'd7, 1'b0});
        idle(); rd = 5'd4; rob_entry_in = 5'd8; tick("ren_r4");
        idle(); valid_wb = 1'b1; rd_wb = 5'd4; rob_entry_wb = 5'd8;
        commit = 1'b1; rd_commit = 5'd4; rob_entry_commit = 5'd8;
        tick("prio4");
        look("prio_cm_wb", 5'd4, '0);

        rand_cycles(400);
        sweep("sweep1");

        idle(); reset = 1'b1; rd = 5'd5; rob_entry_in = 5'd9;
        valid_wb = 1'b1; rd_wb = 5'd1; rob_entry_wb = m_tag[1];
        tick("mid_reset");
        look("mid_reset_r5", 5'd5, '0);
        sweep("sweep_rst");

        rand_cycles(400);
        sweep("sweep2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
